// File: rtl/or1200_biu_arb_if.sv
// Bus bundle between the two cache requesters (IC, DC), the shared BIU and
// the arbiter.
//   master modport : arbiter view. It takes the requests and the BIU responses,
//                    and it drives the grants, the routed acks/errs and the BIU
//                    cycle signals.
//   slave modport  : environment view. This is the requesters plus the bus slave.
interface or1200_biu_arb_if;
  logic        ic_req;
  logic        ic_burst;
  logic [31:0] ic_adr;
  logic        ic_gnt;
  logic        ic_ack;
  logic        ic_err;

  logic        dc_req;
  logic        dc_we;
  logic        dc_burst;
  logic [31:0] dc_adr;
  logic [31:0] dc_dat_i;
  logic        dc_gnt;
  logic        dc_ack;
  logic        dc_err;

  logic        biu_cyc;
  logic        biu_we;
  logic [31:0] biu_adr;
  logic [31:0] biu_dat_o;
  logic        biu_last;
  logic        biu_ack;
  logic        biu_err;

  modport master (
    input  ic_req, ic_burst, ic_adr,
    input  dc_req, dc_we, dc_burst, dc_adr, dc_dat_i,
    input  biu_ack, biu_err,
    output ic_gnt, ic_ack, ic_err,
    output dc_gnt, dc_ack, dc_err,
    output biu_cyc, biu_we, biu_adr, biu_dat_o, biu_last
  );

  modport slave (
    output ic_req, ic_burst, ic_adr,
    output dc_req, dc_we, dc_burst, dc_adr, dc_dat_i,
    output biu_ack, biu_err,
    input  ic_gnt, ic_ack, ic_err,
    input  dc_gnt, dc_ack, dc_err,
    input  biu_cyc, biu_we, biu_adr, biu_dat_o, biu_last
  );
endinterface

// File: rtl/or1200_biu_arb.sv
// The IC refill FSM and the DC FSM share one BIU, and this module arbitrates
// between them. A grant is held for a whole single or BEATS-beat burst. While
// the grant is held, the module generates the wrapped beat addresses and the
// last-beat flag, and it routes ack/err back to the owner only.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active high
//   bus  : or1200_biu_arb_if.master. This carries the requests, the grants,
//          the routed responses and the BIU cycle.
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests
// IC_XFER | IC owns the bus
// DC_XFER | DC owns the bus
module or1200_biu_arb #(
  parameter int BEATS = 4
) (
  input logic              clk,
  input logic              rst,
  or1200_biu_arb_if.master bus
);

  localparam int OFFW = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IC_XFER = 2'd1,
    DC_XFER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OFFW-1:0]   cnt_q, cnt_d;
  logic [31:0]       base_q, base_d;
  logic              burst_q, burst_d;
  logic              we_q, we_d;
  logic              last_dc_q, last_dc_d;   // 1: DC was the last owner

  logic              ic_own, dc_own, cyc;
  logic              ic_win;
  logic              owner_req;
  logic [OFFW-1:0]   beat_idx, off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      burst_q   <= 1'b0;
      we_q      <= 1'b0;
      last_dc_q <= 1'b1;   // the first tie after reset goes to IC
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      burst_q   <= burst_d;
      we_q      <= we_d;
      last_dc_q <= last_dc_d;
    end
  end

  assign ic_own = (state_q == IC_XFER);
  assign dc_own = (state_q == DC_XFER);
  assign cyc    = ic_own | dc_own;

  // Round-robin: on a tie, IC wins only when DC was the last owner.
  assign ic_win    = bus.ic_req & (~bus.dc_req | last_dc_q);
  assign owner_req = ic_own ? bus.ic_req : bus.dc_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    burst_d   = burst_q;
    we_d      = we_q;
    last_dc_d = last_dc_q;
    unique case (state_q)
      IDLE: begin
        if (ic_win) begin
          state_d   = IC_XFER;
          base_d    = bus.ic_adr;
          burst_d   = bus.ic_burst;
          we_d      = 1'b0;
          cnt_d     = bus.ic_burst ? OFFW'(BEATS - 1) : '0;
          last_dc_d = 1'b0;
        end else if (bus.dc_req) begin
          state_d   = DC_XFER;
          base_d    = bus.dc_adr;
          burst_d   = bus.dc_burst;
          we_d      = bus.dc_we;
          cnt_d     = bus.dc_burst ? OFFW'(BEATS - 1) : '0;
          last_dc_d = 1'b1;
        end
      end
      IC_XFER, DC_XFER: begin
        // Every exit goes through IDLE, which forces a dead bus cycle.
        if (bus.biu_err) begin
          state_d = IDLE;
        end else if (!owner_req) begin
          state_d = IDLE;
        end else if (bus.biu_ack) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - OFFW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The critical word goes first. The offset field then counts up modulo
  // BEATS, and the upper bits of the address stay fixed.
  assign beat_idx = burst_q ? (OFFW'(BEATS - 1) - cnt_q) : '0;
  assign off      = base_q[OFFW+1:2] + beat_idx;

  assign bus.ic_gnt    = ic_own;
  assign bus.dc_gnt    = dc_own;
  assign bus.biu_cyc   = cyc;
  assign bus.biu_we    = cyc & we_q;
  assign bus.biu_adr   = cyc ? {base_q[31:OFFW+2], off, base_q[1:0]} : 32'h0;
  assign bus.biu_last  = cyc & (cnt_q == '0);
  assign bus.biu_dat_o = dc_own ? bus.dc_dat_i : 32'h0;

  assign bus.ic_ack = bus.biu_ack & ic_own;
  assign bus.ic_err = bus.biu_err & ic_own;
  assign bus.dc_ack = bus.biu_ack & dc_own;
  assign bus.dc_err = bus.biu_err & dc_own;

endmodule

// File: tb/tb_or1200_biu_arb.sv
module tb_or1200_biu_arb;
  localparam int BEATS = 4;

  typedef struct {
    logic [31:0] adr;
    logic        last;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  beat_t sb_q[$];

  or1200_biu_arb_if bus_if();

  or1200_biu_arb #(.BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected beats of a transfer, wrapped independently of the DUT's formulation.
  task automatic push_line(input logic [31:0] start, input bit burst,
                           input bit we, input logic [31:0] dat);
    logic [31:0] mask;
    int n;
    beat_t b;
    mask = 32'(BEATS - 1) << 2;
    n = burst ? BEATS : 1;
    for (int i = 0; i < n; i++) begin
      b.adr  = (start & ~mask) | ((start + 32'(i * 4)) & mask);
      b.last = (i == n - 1);
      b.we   = we;
      b.dat  = dat;
      sb_q.push_back(b);
    end
  endtask

  // Call this at a negedge within an owned cycle. It returns at the next negedge.
  task automatic beat(input bit dc, input bit err, input bit drop_req);
    beat_t e;
    if (err) bus_if.biu_err = 1'b1;
    else     bus_if.biu_ack = 1'b1;
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("biu_adr",   bus_if.biu_adr,   e.adr);
      chk("biu_last",  32'(bus_if.biu_last), 32'(e.last));
      chk("biu_we",    32'(bus_if.biu_we),   32'(e.we));
      chk("biu_dat_o", bus_if.biu_dat_o, e.dat);
    end
    chk("own_ack",   32'(dc ? bus_if.dc_ack : bus_if.ic_ack), 32'(!err));
    chk("own_err",   32'(dc ? bus_if.dc_err : bus_if.ic_err), 32'(err));
    chk("other_ack", 32'(dc ? bus_if.ic_ack : bus_if.dc_ack), 32'd0);
    chk("other_err", 32'(dc ? bus_if.ic_err : bus_if.dc_err), 32'd0);
    @(posedge clk);
    #1;
    bus_if.biu_ack = 1'b0;
    bus_if.biu_err = 1'b0;
    if (drop_req) begin
      if (dc) bus_if.dc_req = 1'b0;
      else    bus_if.ic_req = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_gnt(input bit dc);
    bit got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (dc ? bus_if.dc_gnt : bus_if.ic_gnt) got = 1;
    end
    chk(dc ? "dc_gnt_wait" : "ic_gnt_wait", 32'(got), 32'd1);
  endtask

  always @(negedge clk) begin
    chk("gnt_excl", 32'(bus_if.ic_gnt & bus_if.dc_gnt), 32'd0);
    chk("cyc_eq_gnt", 32'(bus_if.biu_cyc), 32'(bus_if.ic_gnt | bus_if.dc_gnt));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.ic_req = 0; bus_if.ic_burst = 0; bus_if.ic_adr = 0;
    bus_if.dc_req = 0; bus_if.dc_we = 0; bus_if.dc_burst = 0;
    bus_if.dc_adr = 0; bus_if.dc_dat_i = 0;
    bus_if.biu_ack = 0; bus_if.biu_err = 0;
    #1;
    chk("rst_ic_gnt", 32'(bus_if.ic_gnt), 32'd0);
    chk("rst_dc_gnt", 32'(bus_if.dc_gnt), 32'd0);
    chk("rst_cyc",    32'(bus_if.biu_cyc), 32'd0);
    chk("rst_we",     32'(bus_if.biu_we), 32'd0);
    chk("rst_adr",    bus_if.biu_adr, 32'd0);
    #21 rst = 1'b0;

    // Both request in the first cycle: IC wins, DC follows after the dead cycle.
    @(posedge clk); #1;
    bus_if.ic_req = 1; bus_if.ic_burst = 1; bus_if.ic_adr = 32'h0000_1008;
    bus_if.dc_req = 1; bus_if.dc_we = 1; bus_if.dc_burst = 0;
    bus_if.dc_adr = 32'h0000_2000; bus_if.dc_dat_i = 32'hDEAD_BEEF;
    push_line(32'h0000_1008, 1, 0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("tie1_ic_gnt", 32'(bus_if.ic_gnt), 32'd1);
    chk("tie1_dc_gnt", 32'(bus_if.dc_gnt), 32'd0);
    beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 1);
    chk("ic_dead_cyc", 32'(bus_if.biu_cyc), 32'd0);
    push_line(32'h0000_2000, 0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("dc_after_ic", 32'(bus_if.dc_gnt), 32'd1);
    beat(1, 0, 1);
    chk("dc_dead_cyc", 32'(bus_if.biu_cyc), 32'd0);

    // Tie after DC owned: IC wins. Error on beat 2, then the pending DC read.
    bus_if.ic_req = 1; bus_if.ic_burst = 1; bus_if.ic_adr = 32'h0000_3004;
    bus_if.dc_req = 1; bus_if.dc_we = 0; bus_if.dc_burst = 0;
    bus_if.dc_adr = 32'h0000_2010; bus_if.dc_dat_i = 32'h1234_5678;
    push_line(32'h0000_3004, 1, 0, 32'h0);
    @(negedge clk);
    chk("tie2_ic_gnt", 32'(bus_if.ic_gnt), 32'd1);
    chk("tie2_dc_gnt", 32'(bus_if.dc_gnt), 32'd0);
    beat(0, 0, 0);
    beat(0, 1, 1);
    chk("err_cyc_drop", 32'(bus_if.biu_cyc), 32'd0);
    sb_q.delete();
    push_line(32'h0000_2010, 0, 0, 32'h1234_5678);
    @(negedge clk);
    chk("dc_after_err", 32'(bus_if.dc_gnt), 32'd1);
    beat(1, 0, 1);

    // IC abort after beat 1; an ack in the abort cycle is still forwarded.
    bus_if.ic_req = 1; bus_if.ic_burst = 1; bus_if.ic_adr = 32'h0000_4000;
    push_line(32'h0000_4000, 1, 0, 32'h0);
    @(negedge clk);
    chk("abort_gnt", 32'(bus_if.ic_gnt), 32'd1);
    beat(0, 0, 0);
    bus_if.ic_req = 0;
    beat(0, 0, 0);
    bus_if.biu_ack = 1; #1;
    chk("abort_cyc", 32'(bus_if.biu_cyc), 32'd0);
    chk("abort_noack", 32'(bus_if.ic_ack), 32'd0);
    bus_if.biu_ack = 0;
    sb_q.delete();
    bus_if.ic_req = 1; bus_if.ic_burst = 0; bus_if.ic_adr = 32'h0000_5000;
    push_line(32'h0000_5000, 0, 0, 32'h0);
    @(negedge clk);
    chk("restart_gnt", 32'(bus_if.ic_gnt), 32'd1);
    beat(0, 0, 1);

    // Async reset in the middle of a DC write burst.
    bus_if.dc_req = 1; bus_if.dc_we = 1; bus_if.dc_burst = 1;
    bus_if.dc_adr = 32'h0000_6008; bus_if.dc_dat_i = 32'hA5A5_A5A5;
    push_line(32'h0000_6008, 1, 1, 32'hA5A5_A5A5);
    wait_gnt(1);
    beat(1, 0, 0);
    #2 rst = 1'b1; bus_if.biu_ack = 1;
    #1;
    chk("arst_dc_gnt", 32'(bus_if.dc_gnt), 32'd0);
    chk("arst_ic_gnt", 32'(bus_if.ic_gnt), 32'd0);
    chk("arst_cyc",    32'(bus_if.biu_cyc), 32'd0);
    chk("arst_adr",    bus_if.biu_adr, 32'd0);
    chk("arst_dc_ack", 32'(bus_if.dc_ack), 32'd0);
    bus_if.biu_ack = 0; bus_if.dc_req = 0;
    sb_q.delete();
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    bus_if.ic_req = 1; bus_if.ic_burst = 0; bus_if.ic_adr = 32'h0000_7004;
    bus_if.dc_req = 1; bus_if.dc_we = 0; bus_if.dc_burst = 0; bus_if.dc_adr = 32'h0000_8000;
    push_line(32'h0000_7004, 0, 0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("tie3_ic_gnt", 32'(bus_if.ic_gnt), 32'd1);
    chk("tie3_dc_gnt", 32'(bus_if.dc_gnt), 32'd0);
    beat(0, 0, 1);
    bus_if.dc_req = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
